// File: rtl/led_pattern_engine.sv
// LED pattern engine: drives NUM_LEDS outputs from a 2-bit command.
// Supports off, steady on, and two configurable blink bursts, with busy/done handshake.
module led_pattern_engine #(
  parameter int NUM_LEDS        = 8,
  parameter int TICK_CYCLES     = 1200000,
  parameter int LONG_OFF_TICKS  = 5,
  parameter int LONG_ON_TICKS   = 10,
  parameter int LONG_REPS       = 3,
  parameter int SHORT_OFF_TICKS = 2,
  parameter int SHORT_ON_TICKS  = 2,
  parameter int SHORT_REPS      = 5
) (
  input  logic                hwclk,
  input  logic                rst_n,
  input  logic [1:0]          cmd,
  input  logic                cmd_valid,
  input  logic [NUM_LEDS-1:0] led_mask,
  output logic [NUM_LEDS-1:0] leds,
  output logic                busy,
  output logic                done
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  localparam logic [7:0] L_OFF  = 8'(LONG_OFF_TICKS);
  localparam logic [7:0] L_ON   = 8'(LONG_ON_TICKS);
  localparam logic [7:0] L_REPS = 8'(LONG_REPS);
  localparam logic [7:0] S_OFF  = 8'(SHORT_OFF_TICKS);
  localparam logic [7:0] S_ON   = 8'(SHORT_ON_TICKS);
  localparam logic [7:0] S_REPS = 8'(SHORT_REPS);

  typedef enum logic [1:0] {
    IDLE_OFF,
    STEADY_ON,
    PH_OFF,
    PH_ON
  } state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         presc, presc_nxt;
  logic [7:0]            phase_cnt, phase_nxt;
  logic [7:0]            rep_cnt, rep_nxt;
  logic                  burst_long, burst_long_nxt;
  logic [NUM_LEDS-1:0]   mask, mask_nxt;
  logic [NUM_LEDS-1:0]   leds_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  tick;
  logic [7:0]            off_ticks, on_ticks;

  assign tick      = (presc == PRESC_LAST);
  assign off_ticks = burst_long ? L_OFF : S_OFF;
  assign on_ticks  = burst_long ? L_ON  : S_ON;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_OFF;
      presc      <= '0;
      phase_cnt  <= '0;
      rep_cnt    <= '0;
      burst_long <= 1'b0;
      mask       <= '0;
      leds       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      phase_cnt  <= phase_nxt;
      rep_cnt    <= rep_nxt;
      burst_long <= burst_long_nxt;
      mask       <= mask_nxt;
      leds       <= leds_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // A valid command always takes priority, which both pre-empts bursts and suppresses done.
  always_comb begin
    state_nxt      = state;
    presc_nxt      = tick ? '0 : presc + 1'b1;
    phase_nxt      = phase_cnt;
    rep_nxt        = rep_cnt;
    burst_long_nxt = burst_long;
    mask_nxt       = mask;
    done_nxt       = 1'b0;

    if (cmd_valid) begin
      mask_nxt  = led_mask;
      presc_nxt = '0;
      unique case (cmd)
        2'b00: begin
          state_nxt = IDLE_OFF;
          phase_nxt = '0;
          rep_nxt   = '0;
        end
        2'b01: begin
          state_nxt = STEADY_ON;
          phase_nxt = '0;
          rep_nxt   = '0;
        end
        2'b10: begin
          state_nxt      = PH_OFF;
          burst_long_nxt = 1'b1;
          phase_nxt      = L_OFF;
          rep_nxt        = L_REPS;
        end
        default: begin
          state_nxt      = PH_OFF;
          burst_long_nxt = 1'b0;
          phase_nxt      = S_OFF;
          rep_nxt        = S_REPS;
        end
      endcase
    end else begin
      unique case (state)
        PH_OFF: begin
          if (tick) begin
            if (phase_cnt == 8'd1) begin
              state_nxt = PH_ON;
              phase_nxt = on_ticks;
            end else begin
              phase_nxt = phase_cnt - 8'd1;
            end
          end
        end
        PH_ON: begin
          if (tick) begin
            if (phase_cnt == 8'd1) begin
              if (rep_cnt == 8'd1) begin
                state_nxt = IDLE_OFF;
                phase_nxt = '0;
                rep_nxt   = '0;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = PH_OFF;
                phase_nxt = off_ticks;
                rep_nxt   = rep_cnt - 8'd1;
              end
            end else begin
              phase_nxt = phase_cnt - 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end

    leds_nxt = ((state_nxt == STEADY_ON) || (state_nxt == PH_ON)) ? mask_nxt : '0;
    busy_nxt = (state_nxt == PH_OFF) || (state_nxt == PH_ON);
  end

endmodule
